// File: rtl/input_ram_pkg.sv
// Shared definitions for the 1-bit x 1024-entry input RAM and its byte-stream loader.
package input_ram_pkg;

   localparam int unsigned ADDR_WIDTH = 10;
   localparam int unsigned DATA_WIDTH = 1;
   localparam int unsigned DEPTH      = 1024;
   localparam int unsigned BYTE_WIDTH = 8;

   typedef enum logic [1:0] {
      StIdle,
      StWaitByte,
      StUnpack,
      StDone
   } loader_state_e;

endpackage

// File: rtl/input_ram_loader.sv
// Fills the input RAM from a byte stream, one bit per cycle, LSB of each byte first.
module input_ram_loader
   import input_ram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = input_ram_pkg::ADDR_WIDTH,
   parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH,
   parameter int unsigned BYTE_WIDTH = input_ram_pkg::BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BYTE_WIDTH-1:0] byte_in,
   input  logic                  byte_vld,
   output logic                  byte_rdy,
   output logic                  ram_data,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned BitW = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
   localparam logic [BitW-1:0]       BitLast  = BitW'(BYTE_WIDTH - 1);
   localparam logic [ADDR_WIDTH-1:0] AddrLast = ADDR_WIDTH'(DEPTH - 1);

   loader_state_e         state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BitW-1:0]       bit_q, bit_d;
   logic [BYTE_WIDTH-1:0] shreg_q, shreg_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      byte_rdy = 1'b0;
      ram_we   = 1'b0;
      ram_data = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               addr_d  = '0;
               state_d = StWaitByte;
            end
         end
         StWaitByte: begin
            busy     = 1'b1;
            byte_rdy = 1'b1;
            if (byte_vld) begin
               shreg_d = byte_in;
               bit_d   = '0;
               state_d = StUnpack;
            end
         end
         StUnpack: begin
            busy     = 1'b1;
            ram_we   = 1'b1;
            ram_data = shreg_q[0];
            shreg_d  = shreg_q >> 1;
            addr_d   = addr_q + 1'b1;
            bit_d    = bit_q + 1'b1;
            // The write to the top address ends the load; the wrapped counter is never used.
            if (bit_q == BitLast) begin
               state_d = (addr_q == AddrLast) ? StDone : StWaitByte;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign ram_addr = addr_q;

endmodule

// File: doc/input_ram_loader.md
Name: input_ram_loader

Overview:
Upstream fill stage for the 1-bit x 1024-entry input RAM, i.e. the image/feature-bit store. It accepts a byte stream over a valid/ready handshake and unpacks each byte LSB-first into eight consecutive single-bit RAM writes. It fills addresses 0..DEPTH-1 in one load and pulses done on completion. Its ram_* outputs connect directly to the RAM's data/addr/we pins; it shares the RAM's clock.

Parameters:
ADDR_WIDTH, 10, RAM address width; must equal the input RAM's address width.
DEPTH, 2**ADDR_WIDTH (1024), number of bits loaded per load; must be a multiple of 8.
BYTE_WIDTH, 8, width of incoming stream words.

Ports:
clk  input  1  system clock, all state on posedge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; begins a load; sampled only in IDLE.
byte_in  input  BYTE_WIDTH  stream data.
byte_vld  input  1  byte_in valid.
byte_rdy  output  1  loader can accept a byte this cycle.
ram_data  output  1  bit to write (RAM data pin).
ram_addr  output  ADDR_WIDTH  RAM write address.
ram_we  output  1  RAM write enable.
busy  output  1  high from the cycle after start until done.
done  output  1  one-cycle pulse when all DEPTH bits are written.

Behaviour:
- Reset (async, immediate): state=IDLE, addr_cnt=0, bit_cnt=0, shreg=0. Outputs: byte_rdy=0, ram_we=0, ram_addr=0, ram_data=0, busy=0, done=0.
- States: IDLE, WAIT_BYTE, UNPACK, DONE.
- IDLE: byte_rdy=0. On start: addr_cnt<=0, go to WAIT_BYTE. Otherwise hold.
- WAIT_BYTE: byte_rdy=1. On byte_vld&&byte_rdy (cycle T): shreg<=byte_in, bit_cnt<=0, go to UNPACK. byte_vld without a transfer consumes nothing.
- UNPACK: ram_we=1, ram_data=shreg[0], ram_addr=addr_cnt, all driven combinationally from registers.
  - Each cycle: shreg>>=1, addr_cnt++, bit_cnt++.
  - After the 8th write (bit_cnt==7): if addr_cnt==DEPTH-1, go to DONE; else go to WAIT_BYTE.
  - Writes therefore occur in T+1..T+8, and byte_rdy reasserts in T+9.
  - byte_rdy=0 throughout UNPACK; there is no overlap or buffering.
- DONE: done=1 for exactly one cycle, ram_we=0, then IDLE.
- busy=1 in WAIT_BYTE and UNPACK; busy=0 in IDLE and DONE.
- Bit order: byte k bit j is written to address 8k+j.
- addr_cnt is ADDR_WIDTH bits. Its increment after address DEPTH-1 wraps to 0; DONE is entered from that same write, so no write beyond DEPTH-1 ever occurs.
- Throughput: with byte_vld held high, 9 cycles per byte. A full load of 128 bytes takes 1152 cycles. With start at cycle S, done is high at S+1153.
- start while busy, or while in DONE: ignored, no restart.
- Stalls: byte_vld low in WAIT_BYTE holds the state indefinitely; there is no timeout.
- rst mid-load: abort immediately, ram_we drops asynchronously, and no done pulse is generated. RAM bits already written are left as-is; a new start reloads from address 0.
- byte_in changes during UNPACK have no effect, since the byte is captured in shreg.

Decomposition:
- Shared package (input_ram_pkg):
  - ADDR_WIDTH=10, DATA_WIDTH=1, DEPTH=1024, BYTE_WIDTH=8.
  - Loader state enum {IDLE, WAIT_BYTE, UNPACK, DONE}.
  - The input RAM and this loader both import it.
- Single flat module; no sub-module is warranted. The shift register and counters are small.
- The bench instantiates the loader together with the input RAM for end-to-end checks.

Test Plan:
1. Reset then idle: hold rst 3 cycles, no start -> byte_rdy=0, ram_we=0, busy=0, done=0. Asserting rst mid-cycle drives outputs low without waiting for a clk edge.
2. Full load, back-to-back: start, then 128 bytes of 0xA5 with byte_vld held high.
   - RAM addr 0..7 = 1,0,1,0,0,1,0,1 (LSB first), repeating.
   - done is high exactly at S+1153; busy falls the same cycle.
   - Exactly 1024 ram_we cycles are seen.
3. Stalled source: byte_vld low for 5 cycles between every byte, bytes 0x00..0x7F.
   - Address 8k+j holds bit j of k; no writes occur during stalls.
   - Total 128 handshakes and 1024 writes.
4. Boundary: last byte 0x80 -> the final write is addr 1023 with data 1. ram_addr is never seen wrapping to 0 with ram_we=1. done follows one cycle after the addr-1023 write.
5. Ignored start: pulse start during UNPACK of byte 40 and again in the DONE cycle -> no restart, addr sequence unbroken, exactly one done pulse.
6. Reset mid-load: rst during the write to addr 300, then a new start with 128 bytes of 0xFF -> all 1024 RAM bits read back 1, one done pulse.
